// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache to memory arbiter.
package rv32i_types;

   localparam int LINE_BITS        = 256;
   localparam int LINE_OFFSET_BITS = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the cacheline adaptor.
interface cache_arbiter_if #(
   parameter int LINE_BITS = rv32i_types::LINE_BITS,
   parameter int ADDR_BITS = 32
);
   logic                 i_pmem_read;
   logic [ADDR_BITS-1:0] i_pmem_address;
   logic [LINE_BITS-1:0] i_pmem_rdata;
   logic                 i_pmem_resp;

   logic                 d_pmem_read;
   logic                 d_pmem_write;
   logic [ADDR_BITS-1:0] d_pmem_address;
   logic [LINE_BITS-1:0] d_pmem_wdata;
   logic [LINE_BITS-1:0] d_pmem_rdata;
   logic                 d_pmem_resp;

   logic                 mem_read;
   logic                 mem_write;
   logic [ADDR_BITS-1:0] mem_address;
   logic [LINE_BITS-1:0] mem_wdata;
   logic [LINE_BITS-1:0] mem_rdata;
   logic                 mem_resp;

   modport slave (
      input  i_pmem_read, i_pmem_address,
      output i_pmem_rdata, i_pmem_resp,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output d_pmem_rdata, d_pmem_resp,
      output mem_read, mem_write, mem_address, mem_wdata,
      input  mem_rdata, mem_resp
   );

   modport master (
      output i_pmem_read, i_pmem_address,
      input  i_pmem_rdata, i_pmem_resp,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  d_pmem_rdata, d_pmem_resp,
      input  mem_read, mem_write, mem_address, mem_wdata,
      output mem_rdata, mem_resp
   );
endinterface

// File: rtl/cache_arbiter_control.sv
// Round-robin grant FSM for the cache arbiter.
//   state   | meaning
//   IDLE    | no transaction; grant a pending requester
//   SERVE_I | I-cache line fill outstanding at the adaptor
//   SERVE_D | D-cache fill or writeback outstanding at the adaptor
//   RELEASE | one quiet cycle so the served cache can drop its request
module arbiter_control
   import rv32i_types::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_req,
   input  logic       d_req,
   input  logic       mem_resp,
   output arb_state_t state_o,
   output logic       grant_o,
   output grant_t     grant_sel_o
);

   arb_state_t state_q, state_d;
   grant_t     last_grant_q, last_grant_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_I;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (grant_o) begin
               state_d      = (grant_sel_o == GRANT_D) ? SERVE_D : SERVE_I;
               last_grant_d = grant_sel_o;
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem_resp) state_d = RELEASE;
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // On contention the side that did not win last time gets the grant.
   always_comb begin
      state_o     = state_q;
      grant_o     = (state_q == IDLE) && (i_req || d_req);
      grant_sel_o = (d_req && (!i_req || last_grant_q == GRANT_I)) ? GRANT_D : GRANT_I;
   end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line traffic onto one cacheline adaptor.
module cache_arbiter #(
   parameter int LINE_BITS = rv32i_types::LINE_BITS,
   parameter int ADDR_BITS = 32
) (
   input  logic            clk,
   input  logic            rst,
   cache_arbiter_if.slave  bus,
   output logic            busy
);
   import rv32i_types::*;

   arb_state_t           state;
   logic                 grant;
   grant_t               grant_sel;
   logic                 d_req;
   logic                 serving;

   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic                 write_q, write_d;
   logic [LINE_BITS-1:0] wdata_q, wdata_d;

   assign d_req = bus.d_pmem_read | bus.d_pmem_write;

   arbiter_control u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .i_req       (bus.i_pmem_read),
      .d_req       (d_req),
      .mem_resp    (bus.mem_resp),
      .state_o     (state),
      .grant_o     (grant),
      .grant_sel_o (grant_sel)
   );

   // Write wins when the D-cache raises both strobes.
   always_comb begin
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      if (grant) begin
         if (grant_sel == GRANT_D) begin
            addr_d  = {bus.d_pmem_address[ADDR_BITS-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
            write_d = bus.d_pmem_write;
            wdata_d = bus.d_pmem_wdata;
         end else begin
            addr_d  = {bus.i_pmem_address[ADDR_BITS-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
            write_d = 1'b0;
            wdata_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else begin
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
      end
   end

   // Adaptor command depends only on registered state, never on live requests.
   assign serving         = (state == SERVE_I) || (state == SERVE_D);
   assign bus.mem_read    = serving && !write_q;
   assign bus.mem_write   = serving && write_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_wdata   = wdata_q;

   assign bus.i_pmem_resp  = (state == SERVE_I) && bus.mem_resp && !rst;
   assign bus.d_pmem_resp  = (state == SERVE_D) && bus.mem_resp && !rst;
   assign bus.i_pmem_rdata = (state == SERVE_I) ? bus.mem_rdata : '0;
   assign bus.d_pmem_rdata = (state == SERVE_D) ? bus.mem_rdata : '0;

   assign busy = (state != IDLE) || bus.i_pmem_read || d_req;

   a_d_rw_excl: assert property (@(posedge clk) disable iff (rst)
                                 !(bus.d_pmem_read && bus.d_pmem_write))
      else $error("d_pmem_read and d_pmem_write both high; servicing as write");

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed and randomized bench for cache_arbiter with a transaction-level model.
module tb_cache_arbiter;
   localparam int LB = 256;
   localparam int AB = 32;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   cache_arbiter_if #(.LINE_BITS(LB), .ADDR_BITS(AB)) bus ();

   cache_arbiter #(.LINE_BITS(LB), .ADDR_BITS(AB)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ob_cyc;

   // Model: who owns the adaptor (0 none, 1 I, 2 D), release gap, last winner.
   int          m_owner = 0;
   bit          m_rel   = 0;
   bit          m_last_d = 0;
   bit          m_valid = 0;
   logic [31:0] m_addr;
   bit          m_wr;
   logic [255:0] m_wdata;

   logic         ob_mem_read, ob_mem_write, ob_i_resp, ob_d_resp, ob_busy;
   logic [31:0]  ob_mem_addr;
   logic [255:0] ob_mem_wdata, ob_i_rdata, ob_d_rdata;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, ob_cyc, act, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // One clock: compare at the falling edge, then advance the model.
   task automatic tick();
      bit serving, drq;
      @(negedge clk);
      ob_cyc       = cyc;
      ob_mem_read  = bus.mem_read;
      ob_mem_write = bus.mem_write;
      ob_mem_addr  = bus.mem_address;
      ob_mem_wdata = bus.mem_wdata;
      ob_i_resp    = bus.i_pmem_resp;
      ob_d_resp    = bus.d_pmem_resp;
      ob_i_rdata   = bus.i_pmem_rdata;
      ob_d_rdata   = bus.d_pmem_rdata;
      ob_busy      = busy;
      drq     = bus.d_pmem_read || bus.d_pmem_write;
      serving = (m_owner != 0) && !m_rel;
      if (m_valid) begin
         chk("mem_read",  ob_mem_read,  serving && !m_wr);
         chk("mem_write", ob_mem_write, serving && m_wr);
         chk("busy",      ob_busy,      (m_owner != 0) || bus.i_pmem_read || drq);
         chk("i_resp",    ob_i_resp,    serving && m_owner == 1 && bus.mem_resp && !rst);
         chk("d_resp",    ob_d_resp,    serving && m_owner == 2 && bus.mem_resp && !rst);
         if (serving) chk("mem_address", ob_mem_addr, m_addr);
         if (serving && m_wr) chk("mem_wdata", ob_mem_wdata, m_wdata);
         if (serving && m_owner == 1 && bus.mem_resp) chk("i_rdata", ob_i_rdata, bus.mem_rdata);
         else if (m_owner != 1) chk("i_rdata_zero", ob_i_rdata, '0);
         if (serving && m_owner == 2 && bus.mem_resp) chk("d_rdata", ob_d_rdata, bus.mem_rdata);
         else if (m_owner != 2) chk("d_rdata_zero", ob_d_rdata, '0);
      end
      if (rst) begin
         m_owner = 0; m_rel = 0; m_last_d = 0; m_addr = '0; m_wr = 0; m_wdata = '0; m_valid = 1;
      end else if (m_valid) begin
         if (m_rel) begin
            m_owner = 0; m_rel = 0;
         end else if (m_owner != 0) begin
            if (bus.mem_resp) m_rel = 1;
         end else if (drq && (!bus.i_pmem_read || !m_last_d)) begin
            m_owner = 2; m_last_d = 1; m_addr = bus.d_pmem_address & ~32'h1f;
            m_wr = bus.d_pmem_write; m_wdata = bus.d_pmem_wdata;
         end else if (bus.i_pmem_read) begin
            m_owner = 1; m_last_d = 0; m_addr = bus.i_pmem_address & ~32'h1f;
            m_wr = 0; m_wdata = '0;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.i_pmem_read = 0; bus.d_pmem_read = 0; bus.d_pmem_write = 0;
      bus.mem_resp = 0;
   endtask

   task automatic do_reset();
      rst = 1; quiet();
      tick();
      rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] p;
      int pulses;
      logic [255:0] got;
      int nresp, nstart, run, req_cyc;
      int start_c [4];
      int resp_c  [4];
      bit who_d   [4];
      bit i_act, d_act, i_done, d_done, ob_cmd;

      rst = 1; quiet();
      bus.i_pmem_address = '0; bus.d_pmem_address = '0;
      bus.d_pmem_wdata = '0; bus.mem_rdata = '0;
      @(posedge clk); #1;
      tick();
      // second reset cycle with a stray adaptor response
      bus.mem_resp = 1;
      tick();
      chk("rst_mem_read",  ob_mem_read, 0);
      chk("rst_mem_write", ob_mem_write, 0);
      chk("rst_i_resp",    ob_i_resp, 0);
      chk("rst_d_resp",    ob_d_resp, 0);
      chk("rst_mem_addr",  ob_mem_addr, 32'h0);
      chk("rst_busy",      ob_busy, 0);
      rst = 0; bus.mem_resp = 0;

      // I read, addr 0x104, response on the fifth command cycle
      bus.i_pmem_read = 1; bus.i_pmem_address = 32'h0000_0104;
      tick();
      chk("t1_cmd_not_same_cycle", ob_mem_read, 0);
      pulses = 0; p = rand_line(); got = '0;
      for (int k = 1; k <= 5; k++) begin
         bus.mem_resp = (k == 5); bus.mem_rdata = (k == 5) ? p : rand_line();
         tick();
         if (k == 1) begin
            chk("t1_mem_read", ob_mem_read, 1);
            chk("t1_mem_addr", ob_mem_addr, 32'h0000_0100);
         end
         if (ob_i_resp) begin pulses++; got = ob_i_rdata; end
      end
      bus.mem_resp = 0; bus.i_pmem_read = 0;
      tick();
      if (ob_i_resp) pulses++;
      chk("t1_release_cmd", ob_mem_read, 0);
      tick();
      chk("t1_resp_pulses", pulses, 1);
      chk("t1_rdata", got, p);

      // D writeback of an A5 pattern
      bus.d_pmem_write = 1; bus.d_pmem_address = 32'h2000_0040;
      bus.d_pmem_wdata = {32{8'hA5}};
      tick();
      pulses = 0;
      for (int k = 1; k <= 4; k++) begin
         bus.mem_resp = (k == 4);
         tick();
         chk("t2_mem_write", ob_mem_write, 1);
         chk("t2_mem_wdata", ob_mem_wdata, {32{8'hA5}});
         if (ob_d_resp) pulses++;
      end
      bus.mem_resp = 0; bus.d_pmem_write = 0;
      tick();
      if (ob_d_resp) pulses++;
      chk("t2_write_dropped", ob_mem_write, 0);
      tick();
      chk("t2_resp_pulses", pulses, 1);

      // Both requesters held across four transactions
      do_reset();
      bus.i_pmem_read = 1; bus.i_pmem_address = 32'h0000_1000;
      bus.d_pmem_read = 1; bus.d_pmem_address = 32'h0000_3000;
      req_cyc = cyc; nresp = 0; nstart = 0; run = 0;
      for (int n = 0; n < 80 && nresp < 4; n++) begin
         bus.mem_rdata = rand_line();
         tick();
         if (ob_mem_read && run == 0 && nstart < 4) begin
            start_c[nstart] = ob_cyc; who_d[nstart] = (ob_mem_addr == 32'h0000_3000); nstart++;
         end
         if (ob_mem_read) run++; else run = 0;
         if ((ob_i_resp || ob_d_resp) && nresp < 4) begin resp_c[nresp] = ob_cyc; nresp++; end
         bus.mem_resp = ob_mem_read && (run == 2);
      end
      bus.mem_resp = 0; quiet();
      tick(); tick();
      chk("t3_resp_count", nresp, 4);
      chk("t3_start_count", nstart, 4);
      if (nresp == 4 && nstart == 4) begin
         chk("t3_first_latency", start_c[0] - req_cyc, 1);
         chk("t3_grant0_d", who_d[0], 1);
         chk("t3_grant1_i", who_d[1], 0);
         chk("t3_grant2_d", who_d[2], 1);
         chk("t3_grant3_i", who_d[3], 0);
         for (int k = 0; k < 3; k++) chk("t3_resp_to_next_cmd", start_c[k+1] - resp_c[k], 3);
      end

      // Reset in the middle of an I fill
      do_reset();
      bus.i_pmem_read = 1; bus.i_pmem_address = 32'h0000_0500;
      tick();
      tick();
      chk("t4_serving", ob_mem_read, 1);
      rst = 1; bus.i_pmem_read = 0;
      tick();
      chk("t4_no_resp_in_rst", ob_i_resp, 0);
      rst = 0;
      tick();
      chk("t4_aborted", ob_mem_read, 0);
      bus.mem_resp = 1;
      tick();
      chk("t4_late_resp_ignored", ob_i_resp, 0);
      chk("t4_late_resp_busy", ob_busy, 0);
      bus.mem_resp = 0;

      // Stray adaptor response while idle
      bus.mem_resp = 1;
      tick();
      chk("t5_i_resp", ob_i_resp, 0);
      chk("t5_d_resp", ob_d_resp, 0);
      bus.mem_resp = 0;
      tick();
      chk("t5_still_idle", ob_busy, 0);

      // Randomized traffic against the model
      i_act = 0; d_act = 0; i_done = 0; d_done = 0; ob_cmd = 0;
      for (int n = 0; n < 4000; n++) begin
         rst = ($urandom_range(0, 499) == 0);
         if (!i_act && !i_done && $urandom_range(0, 2) == 0) begin
            i_act = 1; bus.i_pmem_address = $urandom;
         end
         if (!d_act && !d_done && $urandom_range(0, 2) == 0) begin
            d_act = 1; bus.d_pmem_address = $urandom; bus.d_pmem_wdata = rand_line();
            if ($urandom_range(0, 1) == 1) begin bus.d_pmem_write = 1; bus.d_pmem_read = 0; end
            else begin bus.d_pmem_write = 0; bus.d_pmem_read = 1; end
         end
         if (!d_act) begin bus.d_pmem_read = 0; bus.d_pmem_write = 0; end
         bus.i_pmem_read = i_act;
         bus.mem_resp  = ob_cmd ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         bus.mem_rdata = rand_line();
         i_done = 0; d_done = 0;
         tick();
         ob_cmd = ob_mem_read || ob_mem_write;
         if (ob_i_resp) begin i_act = 0; i_done = 1; end
         if (ob_d_resp) begin d_act = 0; d_done = 1; end
      end
      rst = 0; quiet();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_BITS, default 256, giving the cacheline width in bits.
REQ-002 The block SHALL have parameter ADDR_BITS, default 32, giving the physical address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port i_pmem_read, input, 1, I-cache line-fill request.
REQ-006 The block SHALL have port i_pmem_address, input, ADDR_BITS, I-cache line address.
REQ-007 The block SHALL have port i_pmem_rdata, output, LINE_BITS, line returned to the I-cache.
REQ-008 The block SHALL have port i_pmem_resp, output, 1, I-cache completion pulse.
REQ-009 The block SHALL have ports d_pmem_read and d_pmem_write, input, 1 each, D-cache fill and writeback requests.
REQ-010 The block SHALL have port d_pmem_address, input, ADDR_BITS, D-cache line address.
REQ-011 The block SHALL have port d_pmem_wdata, input, LINE_BITS, writeback line.
REQ-012 The block SHALL have port d_pmem_rdata, output, LINE_BITS, line returned to the D-cache.
REQ-013 The block SHALL have port d_pmem_resp, output, 1, D-cache completion pulse.
REQ-014 The block SHALL have ports mem_read and mem_write, output, 1 each, commands to the cacheline adaptor.
REQ-015 The block SHALL have port mem_address, output, ADDR_BITS, line-aligned address to the adaptor.
REQ-016 The block SHALL have port mem_wdata, output, LINE_BITS, write line to the adaptor.
REQ-017 The block SHALL have port mem_rdata, input, LINE_BITS, line data from the adaptor.
REQ-018 The block SHALL have port mem_resp, input, 1, adaptor completion pulse.
REQ-019 The block SHALL have port busy, output, 1, high while any transaction is outstanding; the top level uses it to drive the datapath stall input.

Function
REQ-020 The FSM SHALL have four states: IDLE, SERVE_I, SERVE_D and RELEASE.
REQ-021 In IDLE with only a D request (read or write) pending, the FSM SHALL enter SERVE_D next cycle.
REQ-022 In IDLE with only i_pmem_read pending, the FSM SHALL enter SERVE_I next cycle.
REQ-023 In IDLE with both pending, the FSM SHALL grant the requester not recorded in last_grant (round-robin); last_grant SHALL update on every grant.
REQ-024 On grant, the block SHALL latch the address (low 5 bits forced to 0), operation and wdata; mem_* outputs SHALL come only from this latch and stay stable for the whole transaction.
REQ-025 In SERVE_x, the block SHALL hold mem_read or mem_write asserted until mem_resp, with exactly one asserted.
REQ-026 In the mem_resp cycle, the block SHALL pulse the granted requester's resp for one cycle combinationally from mem_resp and drive its rdata from mem_rdata, then enter RELEASE.
REQ-027 In RELEASE, the block SHALL drive no mem command and no resp for one cycle so the requester can drop its request, then enter IDLE.
REQ-028 Each non-granted requester's resp SHALL stay 0; its rdata SHALL be 0 when not granted.
REQ-029 mem_resp in IDLE or RELEASE SHALL be ignored.
REQ-030 If d_pmem_read and d_pmem_write are both asserted, write SHALL take precedence; a simulation assertion SHALL flag it.
REQ-031 busy SHALL equal (state != IDLE) OR any request pending.
REQ-032 Minimum latency SHALL be request to mem command = 1 cycle, mem_resp to next grant = 2 cycles.

Reset
REQ-033 On rst, the block SHALL set state=IDLE, last_grant=I (D wins the first contention), clear the latches, and drive all mem_* and resp outputs to 0.
REQ-034 An rst asserted mid-transaction SHALL abort it with no resp; any later mem_resp SHALL be ignored.

Structure
REQ-035 The arb_state_t enum and the LINE_BITS constant SHALL be defined in rv32i_types.
REQ-036 The FSM plus last_grant SHALL form sub-module arbiter_control; the latch and muxes SHALL stay in cache_arbiter.
REQ-037 The RTL SHALL contain no combinational path from any request input to any mem_* output.

Verification
REQ-038 I read only, addr 0x0000_0104, mem_resp after 5 cycles -> mem_address 0x0000_0100, i_pmem_resp single pulse, i_pmem_rdata = mem_rdata.
REQ-039 D write only, wdata 0xA5..A5 -> mem_write held exactly until mem_resp, mem_wdata stable throughout, d_pmem_resp one pulse.
REQ-040 I and D both asserted first cycle after reset -> D served first, then I granted 2 cycles after D's mem_resp.
REQ-041 Both held continuously for 4 transactions -> grants alternate D, I, D, I.
REQ-042 rst asserted 2 cycles into SERVE_I -> IDLE next cycle, mem_read 0, no i_pmem_resp even if mem_resp arrives later.
REQ-043 Stray mem_resp in IDLE -> no resp pulses, state stays IDLE.
